// File: rtl/output_display_driver.sv
// Converts an 8-bit value to three BCD digits using a sequential double-dabble engine.
// The result drives a multiplexed common-anode 7-segment display with leading-zero blanking.
module output_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  out_val,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  bin_reg, bin_next;
    logic [7:0]  cap_reg, cap_next;
    logic [11:0] scratch_reg, scratch_next;
    logic [2:0]  iter_reg, iter_next;
    logic [7:0]  last_val_reg, last_val_next;
    logic        valid_reg, valid_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [11:0] scratch_adj;

    logic [CNT_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [1:0]       digit_idx_reg, digit_idx_next;
    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic [3:0]       digit_val;
    logic             digit_blank;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble before each shift
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        cap_next      = cap_reg;
        scratch_next  = scratch_reg;
        iter_next     = iter_reg;
        last_val_next = last_val_reg;
        valid_next    = valid_reg;
        bcd_next      = bcd_reg;
        case (state_reg)
            IDLE: begin
                if (!valid_reg || (out_val != last_val_reg)) begin
                    bin_next     = out_val;
                    cap_next     = out_val;
                    scratch_next = '0;
                    iter_next    = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_next, bin_next} = {scratch_adj, bin_reg} << 1;
                iter_next = iter_reg + 3'd1;
                if (iter_reg == 3'd7) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bcd_next      = scratch_reg;
                last_val_next = cap_reg;
                valid_next    = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Scan path reads only the committed bcd, never the scratch register
    always_comb begin
        scan_cnt_next  = scan_cnt_reg + CNT_W'(1);
        digit_idx_next = digit_idx_reg;
        if (scan_cnt_reg == CNT_MAX) begin
            scan_cnt_next  = '0;
            digit_idx_next = (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
        end
        digit_val   = 4'd0;
        digit_blank = 1'b1;
        case (digit_idx_next)
            2'd0: begin
                digit_val   = bcd_reg[3:0];
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit_val   = bcd_reg[7:4];
                digit_blank = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
            end
            2'd2: begin
                digit_val   = bcd_reg[11:8];
                digit_blank = (bcd_reg[11:8] == 4'd0);
            end
            default: begin
                digit_val   = 4'd0;
                digit_blank = 1'b1;
            end
        endcase
        seg_next = digit_blank ? 7'h7F : seg_code(digit_val);
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_an
            assign an_next[gi] = (digit_idx_next != 2'(gi));
        end
    endgenerate
    assign an_next[3] = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bin_reg       <= '0;
            cap_reg       <= '0;
            scratch_reg   <= '0;
            iter_reg      <= '0;
            last_val_reg  <= '0;
            valid_reg     <= 1'b0;
            bcd_reg       <= '0;
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
            an_reg        <= 4'b1110;
            seg_reg       <= 7'h40;
        end else begin
            state_reg     <= state_next;
            bin_reg       <= bin_next;
            cap_reg       <= cap_next;
            scratch_reg   <= scratch_next;
            iter_reg      <= iter_next;
            last_val_reg  <= last_val_next;
            valid_reg     <= valid_next;
            bcd_reg       <= bcd_next;
            scan_cnt_reg  <= scan_cnt_next;
            digit_idx_reg <= digit_idx_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
        end
    end

    assign bcd  = bcd_reg;
    assign busy = (state_reg != IDLE);
    assign an   = an_reg;
    assign seg  = seg_reg;

endmodule
